// File: rtl/fully_connected.sv
// fully_connected: dense output layer. Buffers one feature vector, then computes
// OUT_LEN saturated scores one after another with a single multiply-accumulate per cycle.
module fully_connected #(
  parameter int IN_LEN  = 48,
  parameter int OUT_LEN = 10,
  parameter int DATA_W  = 12,
  parameter int W_W     = 8,
  parameter int FRAC    = 7,
  parameter int ADDR_W  = $clog2(OUT_LEN*(IN_LEN+1))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              in_ready,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out
);

  // state | meaning
  // LOAD  | collecting features, coefficient writes allowed
  // MAC   | one product of neuron out_idx accumulated per cycle
  // EMIT  | scale, add bias, saturate and present one score
  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  localparam int ROW    = IN_LEN + 1;
  localparam int NCOEF  = OUT_LEN * ROW;
  localparam int CNT_W  = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int OIDX_W = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int PROD_W = DATA_W + W_W;
  localparam int ACC_W  = PROD_W + $clog2(IN_LEN) + 1;
  localparam int SUM_W  = ACC_W + 1;

  localparam logic [CNT_W-1:0]  LAST_IN  = CNT_W'(IN_LEN - 1);
  localparam logic [OIDX_W-1:0] LAST_OUT = OIDX_W'(OUT_LEN - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [1:0]               state_q, state_d;
  logic [CNT_W-1:0]         in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]         mac_cnt_q, mac_cnt_d;
  logic [OIDX_W-1:0]        out_idx_q, out_idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     valid_out_q, valid_out_d;
  logic [DATA_W-1:0]        data_out_q, data_out_d;

  logic signed [DATA_W-1:0] buf_q  [IN_LEN];
  logic signed [W_W-1:0]    w_q    [NCOEF];
  logic signed [DATA_W-1:0] bias_q [OUT_LEN];

  logic                     buf_we, cfg_ok;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext, acc_base;
  logic signed [SUM_W-1:0]  shifted_ext, bias_ext, sum;
  logic [DATA_W-1:0]        sat_val;

  assign in_ready  = (state_q == ST_LOAD);
  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;

  assign buf_we  = in_ready && valid_in;
  assign cfg_ok  = in_ready && cfg_we && ({1'b0, cfg_addr} < (ADDR_W+1)'(NCOEF));
  assign rd_addr = ADDR_W'(out_idx_q) * ADDR_W'(ROW) + ADDR_W'(mac_cnt_q);

  always_comb begin
    prod        = buf_q[mac_cnt_q] * w_q[rd_addr];
    prod_ext    = ACC_W'(prod);
    acc_base    = (mac_cnt_q == '0) ? '0 : acc_q;
    shifted_ext = SUM_W'(acc_q >>> FRAC);
    bias_ext    = SUM_W'(bias_q[out_idx_q]);
    sum         = shifted_ext + bias_ext;
    if (sum > SAT_MAX)      sat_val = {1'b0, {(DATA_W-1){1'b1}}};
    else if (sum < SAT_MIN) sat_val = {1'b1, {(DATA_W-1){1'b0}}};
    else                    sat_val = sum[DATA_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    mac_cnt_d   = mac_cnt_q;
    out_idx_d   = out_idx_q;
    acc_d       = acc_q;
    valid_out_d = 1'b0;
    data_out_d  = data_out_q;
    case (state_q)
      ST_LOAD: begin
        if (valid_in) begin
          if (in_cnt_q == LAST_IN) begin
            in_cnt_d  = '0;
            mac_cnt_d = '0;
            state_d   = ST_MAC;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      ST_MAC: begin
        acc_d = acc_base + prod_ext;
        if (mac_cnt_q == LAST_IN) begin
          mac_cnt_d = '0;
          state_d   = ST_EMIT;
        end else begin
          mac_cnt_d = mac_cnt_q + 1'b1;
        end
      end
      ST_EMIT: begin
        valid_out_d = 1'b1;
        data_out_d  = sat_val;
        if (out_idx_q == LAST_OUT) begin
          out_idx_d = '0;
          state_d   = ST_LOAD;
        end else begin
          out_idx_d = out_idx_q + 1'b1;
          state_d   = ST_MAC;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      in_cnt_q    <= '0;
      mac_cnt_q   <= '0;
      out_idx_q   <= '0;
      acc_q       <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      mac_cnt_q   <= mac_cnt_d;
      out_idx_q   <= out_idx_d;
      acc_q       <= acc_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
    end
  end

  // Storage arrays survive reset so a mid-frame abort keeps the coefficients.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[in_cnt_q] <= data_in;
    if (cfg_ok) w_q[cfg_addr] <= cfg_data[W_W-1:0];
    for (int o = 0; o < OUT_LEN; o++) begin
      if (cfg_ok && cfg_addr == ADDR_W'(o*ROW + IN_LEN)) bias_q[o] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_fully_connected.sv
// Bench for fully_connected: a small 4x3 instance for directed/random frames and a
// default 48x10 instance for a full random frame, both against an arithmetic model.
`timescale 1ns/1ps
module tb_fully_connected;
  localparam int SI = 4, SO = 3, SN = SI + 1;
  localparam int LI = 48, LO = 10, LN = LI + 1;
  localparam int FRAC = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;

  logic        s_vin = 0, s_we = 0, s_rdy, s_vout;
  logic [11:0] s_din = 0, s_data = 0, s_dout;
  logic [3:0]  s_addr = 0;
  logic        l_vin = 0, l_we = 0, l_rdy, l_vout;
  logic [11:0] l_din = 0, l_data = 0, l_dout;
  logic [8:0]  l_addr = 0;

  fully_connected #(.IN_LEN(SI), .OUT_LEN(SO)) u_small (
    .clk(clk), .rst(rst), .valid_in(s_vin), .data_in(s_din), .in_ready(s_rdy),
    .cfg_we(s_we), .cfg_addr(s_addr), .cfg_data(s_data),
    .valid_out(s_vout), .data_out(s_dout));

  fully_connected u_large (
    .clk(clk), .rst(rst), .valid_in(l_vin), .data_in(l_din), .in_ready(l_rdy),
    .cfg_we(l_we), .cfg_addr(l_addr), .cfg_data(l_data),
    .valid_out(l_vout), .data_out(l_dout));

  int s_qv[$], s_qc[$], l_qv[$], l_qc[$];
  always @(negedge clk) begin
    if (s_vout) begin s_qv.push_back(int'($signed(s_dout))); s_qc.push_back(cyc); end
    if (l_vout) begin l_qv.push_back(int'($signed(l_dout))); l_qc.push_back(cyc); end
  end

  // reference model state
  int s_w[SO][SI], s_b[SO], s_x[SI];
  int l_w[LO][LI], l_b[LO], l_x[LI];
  int s_e0, l_e0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // score = floor(dot / 2^FRAC) + bias, clamped to the 12-bit signed range
  function automatic int fc_ref(input longint dot, input int b);
    longint q, d;
    d = longint'(1) << FRAC;
    q = dot / d;
    if ((dot % d) != 0 && dot < 0) q = q - 1;
    q = q + b;
    if (q > 2047) q = 2047;
    if (q < -2048) q = -2048;
    return int'(q);
  endfunction

  function automatic int rnd12();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic s_set(input int o, input int i, input int val);
    logic [11:0] v;
    v = 12'(val);
    s_we = 1; s_addr = 4'(o*SN + i); s_data = v;
    @(posedge clk); #1;
    s_we = 0;
    if (i < SI) s_w[o][i] = int'($signed(v[7:0]));
    else s_b[o] = int'($signed(v));
  endtask

  task automatic s_set_all(input int wbyte, input int bias);
    for (int o = 0; o < SO; o++) begin
      for (int i = 0; i < SI; i++) s_set(o, i, wbyte);
      s_set(o, SI, bias);
    end
  endtask

  // last beat may carry a coefficient write (bias of row cfg_o) in the same cycle
  task automatic s_send(input int x[SI], input bit cfg_en, input int cfg_o, input int cfg_v);
    s_qv.delete(); s_qc.delete();
    for (int i = 0; i < SI; i++) begin
      s_vin = 1; s_din = 12'(x[i]); s_x[i] = x[i];
      if (i == SI-1 && cfg_en) begin
        s_we = 1; s_addr = 4'(cfg_o*SN + SI); s_data = 12'(cfg_v);
      end
      @(posedge clk); #1;
    end
    s_vin = 0;
    if (cfg_en) begin s_we = 0; s_b[cfg_o] = cfg_v; end
    s_e0 = cyc;
  endtask

  task automatic s_collect(input string tag);
    int t;
    int last;
    longint dot;
    t = 0;
    last = 0;
    while (s_qv.size() < SO && t < 200) begin @(posedge clk); #1; t++; end
    check({tag, "_count"}, s_qv.size(), SO);
    for (int k = 0; k < SO && k < s_qv.size(); k++) begin
      dot = 0;
      for (int i = 0; i < SI; i++) dot += longint'(s_x[i]) * s_w[k][i];
      last = fc_ref(dot, s_b[k]);
      check({tag, "_score", $sformatf("%0d", k)}, s_qv[k], last);
      check({tag, "_lat", $sformatf("%0d", k)}, s_qc[k] - s_e0, (k+1)*SN);
    end
    check({tag, "_ready"}, s_rdy, 1);
    repeat (2) @(posedge clk);
    #1 check({tag, "_hold"}, int'($signed(s_dout)), last);
  endtask

  task automatic l_wr(input int addr, input int val);
    logic [11:0] v;
    v = 12'(val);
    l_we = 1; l_addr = 9'(addr); l_data = v;
    @(posedge clk); #1;
    l_we = 0;
  endtask

  int x100[SI] = '{100, 100, 100, 100};
  int xmax[SI] = '{2047, 2047, 2047, 2047};
  int xm1[SI]  = '{-1, 0, 0, 0};
  int xp1[SI]  = '{1, 0, 0, 0};
  int xr[SI];

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    longint dot;
    logic [11:0] v;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_s", s_rdy, 1);
    check("rst_vout_s", s_vout, 0);
    check("rst_dout_s", s_dout, 0);
    check("rst_ready_l", l_rdy, 1);
    check("rst_dout_l", l_dout, 0);
    rst = 0;
    @(posedge clk); #1;

    // 1: half weights, zero bias
    s_set_all(8'h40, 0);
    s_send(x100, 0, 0, 0);
    check("t1_busy", s_rdy, 0);
    s_collect("t1");

    // 2: negative bias on row 0
    s_set(0, SI, 12'hFFB);
    s_send(x100, 0, 0, 0);
    s_collect("t2");

    // 3: positive and negative saturation
    s_set_all(8'h7F, 0);
    s_send(xmax, 0, 0, 0);
    s_collect("t3p");
    s_set_all(8'h80, 0);
    s_send(xmax, 0, 0, 0);
    s_collect("t3n");

    // 4: floor shift
    s_set_all(0, 0);
    s_set(0, 0, 1);
    s_send(xm1, 0, 0, 0);
    s_collect("t4m");
    s_send(xp1, 0, 0, 0);
    s_collect("t4p");

    // 5: traffic during MAC is ignored; write on last accept is honoured
    s_set_all(8'h40, 0);
    s_send(x100, 1, 1, 10);
    repeat (3) begin
      s_vin = 1; s_din = 12'h7FF; s_we = 1; s_addr = 0; s_data = 12'h07F;
      @(posedge clk); #1;
    end
    s_vin = 0; s_we = 0;
    s_collect("t5a");
    s_set(1, SI, 0);
    s_send(x100, 0, 0, 0);
    s_collect("t5b");

    // 6: reset mid-frame, then reset during a partial load
    s_send(x100, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1 check("t6_ready", s_rdy, 1);
    check("t6_vout", s_vout, 0);
    @(posedge clk); #1 rst = 0;
    s_vin = 1; s_din = 12'h123;
    repeat (2) begin @(posedge clk); #1; end
    s_vin = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    repeat (30) @(posedge clk);
    #1 check("t6_no_pulse", s_qv.size(), 0);
    s_send(x100, 0, 0, 0);
    s_collect("t6");

    // random frames on the small instance
    for (int f = 0; f < 4; f++) begin
      for (int o = 0; o < SO; o++)
        for (int i = 0; i <= SI; i++) s_set(o, i, int'($urandom_range(0, 4095)));
      for (int i = 0; i < SI; i++) xr[i] = rnd12();
      s_send(xr, 0, 0, 0);
      s_collect($sformatf("rnd%0d", f));
    end

    // 7: default-size instance, random coefficients and features
    for (int o = 0; o < LO; o++) begin
      for (int i = 0; i <= LI; i++) begin
        v = 12'($urandom_range(0, 4095));
        l_wr(o*LN + i, int'(v));
        if (i < LI) l_w[o][i] = int'($signed(v[7:0]));
        else l_b[o] = int'($signed(v));
      end
    end
    l_qv.delete(); l_qc.delete();
    for (int i = 0; i < LI; i++) begin
      l_x[i] = rnd12();
      l_vin = 1; l_din = 12'(l_x[i]);
      @(posedge clk); #1;
    end
    l_vin = 0;
    l_e0 = cyc;
    t = 0;
    while (l_qv.size() < LO && t < LO*LN + 50) begin @(posedge clk); #1; t++; end
    check("t7_count", l_qv.size(), LO);
    for (int k = 0; k < LO && k < l_qv.size(); k++) begin
      dot = 0;
      for (int i = 0; i < LI; i++) dot += longint'(l_x[i]) * l_w[k][i];
      check($sformatf("t7_score%0d", k), l_qv[k], fc_ref(dot, l_b[k]));
      check($sformatf("t7_lat%0d", k), l_qc[k] - l_e0, (k+1)*LN);
    end
    check("t7_ready", l_rdy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
